// File: rtl/fetch_unit.sv
// In-order instruction fetch: issues word requests and buffers returned words for decode.
// Response-to-decode latency is 1 cycle; requests stall while queued words plus in-flight requests reach DEPTH.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [31:0]     resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            ex_valid,
  input  logic            is_branch,
  input  logic            is_jmp,
  input  logic            jmp_reg,
  input  logic [2:0]      fn3,
  input  logic            eq,
  input  logic            lt,
  input  logic            ltu,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] b_imm,
  input  logic [XLEN-1:0] j_imm,
  input  logic [XLEN-1:0] alu_out,
  output logic            redirect,
  output logic            misaligned
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Stale-response counter: redirects may stack while old responses are still returning.
  localparam int DW = CW + 4;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [DW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     qdat_q [DEPTH];
  logic [XLEN-1:0] qpc_q  [DEPTH];

  logic            br_taken, taken;
  logic [XLEN-1:0] target;
  logic            tgt_bit0_unused;
  logic [CW:0]     occupancy;
  logic            issue, resp_keep, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    br_taken = 1'b0;
    case (fn3)
      3'b000:  br_taken = eq;
      3'b001:  br_taken = !eq;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = !lt;
      3'b110:  br_taken = ltu;
      3'b111:  br_taken = !ltu;
      default: br_taken = 1'b0;
    endcase
    taken = is_jmp | (is_branch & br_taken);
    if (is_jmp && jmp_reg)
      target = alu_out & ~XLEN'(1);
    else if (is_jmp)
      target = ex_pc + j_imm;
    else
      target = ex_pc + b_imm;
  end

  assign tgt_bit0_unused = target[0];
  assign redirect   = !rst & ex_valid & taken;
  assign misaligned = redirect & target[1];

  assign occupancy  = {1'b0, count_q} + {1'b0, inflight_q};
  assign req_valid  = !rst & !redirect & (occupancy < (CW+1)'(DEPTH));
  assign req_addr   = fetch_pc_q;
  assign inst_valid = !rst & (count_q != '0);
  assign inst_data  = qdat_q[rd_ptr_q];
  assign inst_pc    = qpc_q[rd_ptr_q];

  assign issue     = req_valid & req_ready;
  assign resp_keep = resp_valid & (drop_q == '0);
  assign push      = resp_keep & !redirect;
  assign pop       = inst_valid & inst_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect) begin
      // Everything outstanding now belongs to the wrong path and must be discarded on return.
      fetch_pc_d = {target[XLEN-1:2], 2'b00};
      resp_pc_d  = {target[XLEN-1:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      inflight_d = '0;
      drop_d     = drop_q + DW'(inflight_q) - DW'(resp_valid);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (resp_valid && (drop_q != '0)) drop_d = drop_q - DW'(1);
      inflight_d = inflight_q + CW'(issue) - CW'(resp_keep);
      if (push) begin
        wr_ptr_d  = ptr_inc(wr_ptr_q);
        resp_pc_d = resp_pc_q + XLEN'(4);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qdat_q[wr_ptr_q] <= resp_data;
      qpc_q[wr_ptr_q]  <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-configurable memory model, decode-stream scoreboard, directed and random phases.
module tb_fetch_unit;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h100;

  logic        clk = 0, rst = 1;
  logic        req_valid, req_ready = 1, resp_valid = 0;
  logic [31:0] req_addr, resp_data = 0;
  logic        inst_valid, inst_ready = 1;
  logic [31:0] inst_data, inst_pc;
  logic        ex_valid = 0, is_branch = 0, is_jmp = 0, jmp_reg = 0;
  logic [2:0]  fn3 = 0;
  logic        eq = 0, lt = 0, ltu = 0;
  logic [31:0] ex_pc = 0, b_imm = 0, j_imm = 0, alu_out = 0;
  logic        redirect, misaligned;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .ex_valid(ex_valid), .is_branch(is_branch), .is_jmp(is_jmp), .jmp_reg(jmp_reg), .fn3(fn3),
    .eq(eq), .lt(lt), .ltu(ltu), .ex_pc(ex_pc), .b_imm(b_imm), .j_imm(j_imm), .alu_out(alu_out),
    .redirect(redirect), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Reference rules for control flow.
  function automatic bit ref_taken(input bit jmp, input bit br, input logic [2:0] f,
                                   input bit e, input bit l, input bit lu);
    if (jmp) return 1'b1;
    if (!br) return 1'b0;
    case (f)
      3'd0: return e;
      3'd1: return !e;
      3'd4: return l;
      3'd5: return !l;
      3'd6: return lu;
      3'd7: return !lu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input bit jmp, input bit jreg, input logic [31:0] pc,
                                             input logic [31:0] bi, input logic [31:0] ji,
                                             input logic [31:0] alu);
    if (jmp && jreg) return alu & 32'hFFFF_FFFE;
    if (jmp) return pc + ji;
    return pc + bi;
  endfunction

  // Memory model: fixed latency per reset segment, in order, never stalled.
  typedef struct { int due; logic [31:0] addr; } mreq_t;
  mreq_t       memq[$];
  logic [31:0] acc_log[$];
  int          lat = 1;
  int          cyc = 0;

  always @(negedge clk) begin
    if (rst) memq.delete();
    else if (req_valid && req_ready) begin
      memq.push_back('{cyc + lat, req_addr});
      acc_log.push_back(req_addr);
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      resp_valid = 1;
      resp_data  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      resp_valid = 0;
      resp_data  = $urandom;
    end
  end

  // Scoreboard: expected decode stream, restarted at reset and on every redirect.
  logic [31:0] expq[$];
  logic [31:0] mon_pc;
  bit          exp_chk = 0, exp_redir = 0, exp_mis = 0;
  logic [31:0] exp_tgt = 0;
  int          pops = 0;

  task automatic restart(input logic [31:0] pc);
    expq.delete();
    for (int i = 0; i < 1024; i++) expq.push_back(pc + 32'(4 * i));
  endtask

  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      pops++;
      if (expq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_underflow: got pc %h, expected no instruction", inst_pc);
      end else begin
        mon_pc = expq.pop_front();
        check("inst_pc", inst_pc, mon_pc);
        check("inst_data", inst_data, mem_word(mon_pc));
      end
    end
    if (exp_chk) begin
      check("redirect", {31'b0, redirect}, {31'b0, exp_redir});
      check("misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
      if (exp_redir) begin
        check("req_valid_in_redirect", {31'b0, req_valid}, 32'd0);
        restart({exp_tgt[31:2], 2'b00});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    ex_valid = 0;
    exp_chk  = 0;
  endtask

  task automatic drive_ex(input bit jmp, input bit br, input bit jreg, input logic [2:0] f,
                          input bit e, input bit l, input bit lu, input logic [31:0] pc,
                          input logic [31:0] bi, input logic [31:0] ji, input logic [31:0] alu);
    ex_valid = 1; is_jmp = jmp; is_branch = br; jmp_reg = jreg; fn3 = f;
    eq = e; lt = l; ltu = lu; ex_pc = pc; b_imm = bi; j_imm = ji; alu_out = alu;
    exp_tgt   = ref_target(jmp, jreg, pc, bi, ji, alu);
    exp_redir = ref_taken(jmp, br, f, e, l, lu);
    exp_mis   = exp_redir & exp_tgt[1];
    exp_chk   = 1;
  endtask

  task automatic expect_fetch(input string name, input logic [31:0] exp);
    int n = acc_log.size();
    int w = 0;
    while (acc_log.size() == n && w < 30) begin tick(); w++; end
    if (acc_log.size() == n) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got no request within 30 cycles, expected %h", name, exp);
    end else check(name, acc_log[n], exp);
  endtask

  task automatic do_reset(input int l);
    @(posedge clk); #1;
    rst = 1; lat = l; req_ready = 1; inst_ready = 1;
    ex_valid = 1; is_jmp = 1; is_branch = 0; exp_chk = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", {31'b0, req_valid}, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_redirect", {31'b0, redirect}, 32'd0);
    check("rst_misaligned", {31'b0, misaligned}, 32'd0);
    acc_log.delete();
    restart(RPC);
    @(posedge clk); #1;
    rst = 0; ex_valid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int p0, w;
    bit got;
    logic [2:0] fl [8];
    fl = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3};

    // Start-up sequence and first-instruction latency.
    do_reset(1);
    @(negedge clk);
    check("start_req_valid", {31'b0, req_valid}, 32'd1);
    check("start_req_addr", req_addr, RPC);
    check("start_inst_valid0", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    check("start_inst_valid1", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    check("inst_valid_rise", {31'b0, inst_valid}, 32'd1);
    repeat (10) tick();
    for (int i = 0; i < 3; i++)
      check("req_addr_seq", (acc_log.size() > i) ? acc_log[i] : 32'hxxxx_xxxx, RPC + 32'(4 * i));

    // Backpressure from decode.
    do_reset(1);
    inst_ready = 0;
    repeat (10) tick();
    check("bp_requests", acc_log.size(), 32'd2);
    @(negedge clk);
    check("bp_req_valid", {31'b0, req_valid}, 32'd0);
    check("bp_inst_valid", {31'b0, inst_valid}, 32'd1);
    tick(); inst_ready = 1;
    tick(); inst_ready = 0;
    repeat (10) tick();
    check("bp_after_pop", acc_log.size(), 32'd3);

    // Conditional branches, every funct3 with the flag clear and set.
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      for (int v = 0; v < 2; v++) begin
        tick();
        drive_ex(1'b0, 1'b1, 1'b0, fl[i], 1'(v), 1'(v), 1'(v), 32'h200, 32'hFFFF_FFF8, 32'h0, 32'h0);
        if (exp_redir) expect_fetch("branch_target", 32'h1F8);
        repeat (3) tick();
      end
    end

    // Register and direct jumps.
    tick();
    drive_ex(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h3003);
    expect_fetch("jalr_3003", 32'h3000);
    repeat (3) tick();
    drive_ex(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h3001);
    expect_fetch("jalr_3001", 32'h3000);
    repeat (3) tick();
    drive_ex(1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h8, 32'h0);
    expect_fetch("jal_wrap", 32'h4);
    repeat (5) tick();

    // Redirect with two requests in flight on a 3-cycle memory.
    do_reset(3);
    tick(); tick();
    drive_ex(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h480, 32'h0, 32'h80, 32'h0);
    got = 0; w = 0;
    tick();
    while (!got && w < 40) begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        got = 1;
        check("first_after_redirect", inst_pc, 32'h500);
      end
      w++;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL first_after_redirect: got no instruction in 40 cycles, expected pc 00000500");
    end

    // Reset in the middle of a stream with a full queue.
    tick(); inst_ready = 0;
    repeat (10) tick();
    @(negedge clk);
    check("full_before_rst", {31'b0, inst_valid}, 32'd1);
    @(posedge clk); #1; rst = 1; restart(RPC);
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    check("midrst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("midrst_req_addr", req_addr, RPC);
    inst_ready = 1;

    // Random traffic against the scoreboard.
    for (int seg = 0; seg < 3; seg++) begin
      do_reset($urandom_range(1, 4));
      p0 = pops;
      for (int c = 0; c < 400; c++) begin
        tick();
        req_ready  = ($urandom_range(0, 3) != 0);
        inst_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 11) == 0)
          drive_ex($urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom), 3'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom);
      end
      check("progress", {31'b0, pops > p0}, 32'd1);
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
